// File: rtl/cplx_add_arbiter.sv
// Round-robin arbiter sharing one registered complex adder among NUM_REQ requesters.
// Define CPLX_ADD_ARB_SAT_EN for signed saturating adds and the sat_flag output.
module cplx_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a_re,
    input  logic [NUM_REQ*DW-1:0] req_a_im,
    input  logic [NUM_REQ*DW-1:0] req_b_re,
    input  logic [NUM_REQ*DW-1:0] req_b_im,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ID_W-1:0]       res_id,
    output logic [DW-1:0]         res_re,
    output logic [DW-1:0]         res_im
`ifdef CPLX_ADD_ARB_SAT_EN
    ,
    output logic                  sat_flag
`endif
);

    localparam int unsigned N = NUM_REQ;

    logic                r_valid;
    logic [ID_W-1:0]     r_id;
    logic [DW-1:0]       r_re;
    logic [DW-1:0]       r_im;
    logic [ID_W-1:0]     r_ptr;

    logic                w_can_issue;
    logic                w_found;
    logic [ID_W-1:0]     w_win;
    logic                w_fire;
    logic [NUM_REQ-1:0]  w_ready;
    logic [DW-1:0]       w_a_re, w_a_im, w_b_re, w_b_im;
    logic [DW-1:0]       w_sum_re, w_sum_im;

    assign w_can_issue = ~r_valid | res_ready;

    // Scan from the pointer upward, wrapping past NUM_REQ-1; first hit wins.
    always_comb begin
        int unsigned idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(r_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = ID_W'(idx);
            end
        end
    end

    assign w_fire = ~rst & w_can_issue & w_found;

    always_comb begin
        w_ready = '0;
        if (w_fire) w_ready[w_win] = 1'b1;
    end

    assign req_ready = w_ready;

    assign w_a_re = req_a_re[w_win*DW +: DW];
    assign w_a_im = req_a_im[w_win*DW +: DW];
    assign w_b_re = req_b_re[w_win*DW +: DW];
    assign w_b_im = req_b_im[w_win*DW +: DW];

`ifdef CPLX_ADD_ARB_SAT_EN
    logic            r_sat;
    logic [DW-1:0]   w_raw_re, w_raw_im;
    logic            w_ovf_re, w_ovf_im;
    logic            w_sat;

    assign w_raw_re = w_a_re + w_b_re;
    assign w_raw_im = w_a_im + w_b_im;
    // Overflow only when both operands share a sign and the sum's sign differs.
    assign w_ovf_re = (w_a_re[DW-1] == w_b_re[DW-1]) && (w_raw_re[DW-1] != w_a_re[DW-1]);
    assign w_ovf_im = (w_a_im[DW-1] == w_b_im[DW-1]) && (w_raw_im[DW-1] != w_a_im[DW-1]);

    always_comb begin
        w_sum_re = w_raw_re;
        w_sum_im = w_raw_im;
        if (w_ovf_re) w_sum_re = w_a_re[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        if (w_ovf_im) w_sum_im = w_a_im[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end

    assign w_sat = w_ovf_re | w_ovf_im;

    always_ff @(posedge clk) begin
        if (rst)         r_sat <= 1'b0;
        else if (w_fire) r_sat <= w_sat;
    end

    assign sat_flag = r_sat;
`else
    assign w_sum_re = w_a_re + w_b_re;
    assign w_sum_im = w_a_im + w_b_im;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_re    <= '0;
            r_im    <= '0;
            r_ptr   <= '0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_id    <= w_win;
            r_re    <= w_sum_re;
            r_im    <= w_sum_im;
            r_ptr   <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
        end else if (r_valid && res_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign res_valid = r_valid;
    assign res_id    = r_id;
    assign res_re    = r_re;
    assign res_im    = r_im;

endmodule

// File: tb/tb_cplx_add_arbiter.sv
// Scoreboard bench for cplx_add_arbiter: directed vectors push expected results,
// a monitor pops and compares every accepted output.
module tb_cplx_add_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_a_re, req_a_im, req_b_re, req_b_im;
    logic              res_valid;
    logic              res_ready;
    logic [IW-1:0]     res_id;
    logic [DW-1:0]     res_re, res_im;
    logic              sat_bit;

`ifdef CPLX_ADD_ARB_SAT_EN
    logic sat_flag;
    assign sat_bit = sat_flag;
`else
    assign sat_bit = 1'b0;
`endif

    cplx_add_arbiter #(.NUM_REQ(NR), .DW(DW), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a_re  (req_a_re),
        .req_a_im  (req_a_im),
        .req_b_re  (req_b_re),
        .req_b_im  (req_b_im),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_re    (res_re),
        .res_im    (res_im)
`ifdef CPLX_ADD_ARB_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input logic [DW-1:0] re, input logic [DW-1:0] im, input logic sat);
        exp_t e;
        e.id  = IW'(id);
        e.re  = re;
        e.im  = im;
`ifdef CPLX_ADD_ARB_SAT_EN
        e.sat = sat;
`else
        e.sat = 1'b0 & sat;
`endif
        sb.push_back(e);
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] are, input logic [DW-1:0] aim,
                          input logic [DW-1:0] bre, input logic [DW-1:0] bim);
        req_a_re[i*DW +: DW] = are;
        req_a_im[i*DW +: DW] = aim;
        req_b_re[i*DW +: DW] = bre;
        req_b_im[i*DW +: DW] = bim;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each output accepted by the downstream is compared against the queue head.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {res_id, res_re, res_im, sat_bit}, '1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", {res_id, res_re, res_im, sat_bit}, {e.id, e.re, e.im, e.sat});
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        rst       = 1'b1;
        res_ready = 1'b1;
        req_valid = '1;
        req_a_re  = '0;
        req_a_im  = '0;
        req_b_re  = '0;
        req_b_im  = '0;

        // Reset state, req_ready forced low while rst is high.
        repeat (2) step();
        @(negedge clk);
        chk("reset_outputs", {res_valid, res_id, res_re, res_im}, '0);
        chk("reset_ready", req_ready, 4'b0000);
        step();
        rst       = 1'b0;
        req_valid = '0;
        step();

        // Continuous round-robin with all requesters valid.
        for (int i = 0; i < NR; i++) set_op(i, i, 10 * i, 100, 200);
        for (int k = 0; k < 8; k++) push(k % 4, 100 + (k % 4), 200 + 10 * (k % 4), 1'b0);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", req_ready, 1 << (k % 4));
            step();
        end
        req_valid = '0;
        repeat (2) step();
        @(negedge clk);
        chk("drain_hold", {res_valid, res_id, res_re, res_im}, {1'b0, 2'd3, 32'd103, 32'd230});
        step();

        // Backpressure: pending result held, requesters 1 and 2 wait.
        res_ready = 1'b0;
        set_op(0, 7, 8, 1, 2);
        req_valid = 4'b0001;
        push(0, 8, 10, 1'b0);
        step();
        set_op(1, 32'h10, 32'h20, 32'h01, 32'h02);
        set_op(2, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 1, 1);
        req_valid = 4'b0110;
        push(1, 32'h11, 32'h22, 1'b0);
        push(2, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_ready", req_ready, 4'b0000);
            chk("stall_frozen", {res_valid, res_id, res_re, res_im}, {1'b1, 2'd0, 32'd8, 32'd10});
            step();
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("release_grant", req_ready, 4'b0010);
        step();
        req_valid = 4'b0100;
        @(negedge clk);
        chk("no_bubble", {res_valid, res_id}, {1'b1, 2'd1});
        chk("bp_grant2", req_ready, 4'b0100);
        step();
        req_valid = '0;
        repeat (2) step();

        // Sparse requests: 3 then 0, pointer wraps to 0 then 1.
        set_op(3, 1000, 2000, 1, 2);
        req_valid = 4'b1000;
        push(3, 1001, 2002, 1'b0);
        @(negedge clk);
        chk("sparse_grant3", req_ready, 4'b1000);
        step();
        set_op(0, 5, 6, 7, 8);
        req_valid = 4'b0001;
        push(0, 12, 14, 1'b0);
        @(negedge clk);
        chk("sparse_grant0", req_ready, 4'b0001);
        step();
        set_op(1, 2, 2, 3, 3);
        req_valid = 4'b0011;
        push(1, 5, 5, 1'b0);
        push(0, 12, 14, 1'b0);
        @(negedge clk);
        chk("ptr_at_1", req_ready, 4'b0010);
        step();
        req_valid = 4'b0001;
        @(negedge clk);
        chk("ptr_wrap_0", req_ready, 4'b0001);
        step();
        req_valid = '0;
        repeat (2) step();

        // Boundary arithmetic on requester 2.
        set_op(2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 1);
        req_valid = 4'b0100;
`ifdef CPLX_ADD_ARB_SAT_EN
        push(2, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
`else
        push(2, 32'h8000_0000, 32'h0000_0000, 1'b0);
`endif
        step();
        set_op(2, 32'hFFFF_FFFB, 3, 2, 4);
        push(2, 32'hFFFF_FFFD, 7, 1'b0);
        step();
        set_op(2, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
`ifdef CPLX_ADD_ARB_SAT_EN
        push(2, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
`else
        push(2, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0);
`endif
        step();
        req_valid = '0;
        repeat (2) step();

        // Reset mid-stream: stalled result discarded, pointer back to 0.
        res_ready = 1'b0;
        set_op(1, 9, 9, 9, 9);
        req_valid = 4'b0010;
        step();
        req_valid = '1;
        rst       = 1'b1;
        @(negedge clk);
        chk("mid_stall_valid", res_valid, 1'b1);
        chk("mid_rst_ready", req_ready, 4'b0000);
        step();
        rst       = 1'b0;
        res_ready = 1'b1;
        set_op(0, 1, 2, 3, 4);
        push(0, 4, 6, 1'b0);
        @(negedge clk);
        chk("mid_reset_outputs", {res_valid, res_id, res_re, res_im}, '0);
        chk("mid_first_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        repeat (3) step();

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cplx_add_arbiter.md
Name: cplx_add_arbiter

Overview:
- Shares one registered complex adder among NUM_REQ requesters, e.g. the per-lag accumulation lanes of the cross-correlator.
- Each requester presents an operand pair with a valid/ready handshake.
- A round-robin arbiter issues one add per cycle into an internal registered complex-add stage.
- The result is returned with the winning requester's ID on a valid/ready output port with backpressure.
- Sits between the correlation lanes and the downstream accumulator/readout logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 32, width of each real/imag operand and result component.
- ID_W, 2, width of res_id; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand-pair valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a_re  in  NUM_REQ*DW  operand A real; requester i occupies bits [i*DW +: DW].
- req_a_im  in  NUM_REQ*DW  operand A imag, same packing.
- req_b_re  in  NUM_REQ*DW  operand B real, same packing.
- req_b_im  in  NUM_REQ*DW  operand B imag, same packing.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_id  out  ID_W  index of the requester that owns the result.
- res_re  out  DW  (A_re + B_re) of the granted pair.
- res_im  out  DW  (A_im + B_im) of the granted pair.

Behaviour:
- Reset (rst=1 at a clock edge):
  - res_valid=0, res_id=0, res_re=0, res_im=0, round-robin pointer=0.
  - req_ready is all-zero whenever rst=1.
  - An in-flight result is discarded.
- Issue condition: can_issue = ~res_valid | res_ready.
- Arbitration (combinational):
  - Search req_valid starting at the pointer index, ascending with wrap from NUM_REQ-1 to 0.
  - The first asserted index wins.
  - req_ready[win] = can_issue & |req_valid; all other req_ready bits are 0.
- Fire:
  - Occurs when req_valid[i] & req_ready[i].
  - On the fire edge: res_re <= a_re+b_re, res_im <= a_im+b_im, res_id <= i, res_valid <= 1, pointer <= (i+1) mod NUM_REQ.
- Latency: exactly 1 cycle from the fire edge to res_valid. Sustained throughput is 1 add per cycle while res_ready=1.
- Drain: if res_valid & res_ready and no fire occurs, res_valid <= 0. res_re, res_im and res_id keep their last values.
- Stall: if res_valid & ~res_ready, then req_ready=0 and all result registers hold.
- Simultaneous output accept and new fire: the register takes the new result and res_valid stays 1; no bubble.
- Pointer: unchanged when there is no fire. A requester not served within NUM_REQ fires is impossible; starvation-free.
- Requester rule: once asserted, req_valid and operands must stay stable until ready. The arbiter does not require this for correctness, but fairness depends on it.
- Arithmetic: two's-complement, modulo 2^DW wrap. Carry out is dropped.
- NUM_REQ=1 is not supported.

Optional Feature:
- Macro: CPLX_ADD_ARB_SAT_EN.
- When defined:
  - Each component is a signed saturating add.
  - Positive overflow yields 2^(DW-1)-1; negative overflow yields -2^(DW-1).
  - Extra output sat_flag (1 bit) is registered with the result. It is 1 if either component saturated, 0 at reset, and holds under stall.
- When undefined:
  - Plain modulo wrap add.
  - No sat_flag port.
  - Timing and handshakes are identical in both builds.

Test Plan:
- Reset mid-stream:
  - Stimulus: res_valid=1 with res_ready=0, then assert rst for 1 cycle.
  - Required: next cycle res_valid=0 and res_re=res_im=res_id=0; first grant afterwards goes to requester 0 when all valid.
- All four requesters valid continuously with res_ready=1:
  - Grants go 0,1,2,3,0...
  - Requester i supplies a=(i,10*i), b=(100,200); expect res=(100+i, 200+10*i) with res_id=i, one per cycle.
- Backpressure:
  - Stimulus: res_ready=0 for 3 cycles while requesters 1 and 2 are valid.
  - Required: req_ready=0 and outputs frozen throughout; after res_ready=1, the pending result is accepted and requester 1 is granted in the same cycle with no bubble.
- Sparse requests:
  - Stimulus: only requester 3 valid, then only requester 0 one cycle later.
  - Required: grants 3 then 0; pointer wraps to 0 and then 1.
- Wrap arithmetic (macro off):
  - Stimulus: a_re=0x7FFFFFFF, b_re=1; a_im=0xFFFFFFFF, b_im=1.
  - Required: res_re=0x80000000, res_im=0x00000000.
- Saturation (macro on), same stimulus:
  - Required: res_re=0x7FFFFFFF, res_im=0, sat_flag=1.
  - Then a=(-5,3), b=(2,4) -> res=(-3,7), sat_flag=0.
